// File: rtl/xmm_writeback_arbiter.sv
// rtl/xmm_writeback_arbiter.sv - XMM writeback arbiter with destination scoreboard
// Optional XMM_WB_ROUND_ROBIN_EN selects round-robin arbitration; default is fixed FPU > MEM > ALU.
module xmm_writeback_arbiter #(
  parameter int NUM_XMM = 8,
  parameter int ADDR_W  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               alu_valid,
  input  logic               mem_valid,
  input  logic               fpu_valid,
  input  logic [ADDR_W-1:0]  alu_addr,
  input  logic [ADDR_W-1:0]  mem_addr,
  input  logic [ADDR_W-1:0]  fpu_addr,
  output logic               alu_ready,
  output logic               mem_ready,
  output logic               fpu_ready,
  output logic               xmm_write_en,
  output logic [ADDR_W-1:0]  xmm_write_addr,
  output logic [1:0]         src,
  input  logic               rsv_valid,
  input  logic [ADDR_W-1:0]  rsv_addr,
  output logic               rsv_ok,
  output logic [NUM_XMM-1:0] busy
);

  typedef enum logic [1:0] {
    SRC_IDLE = 2'b00,
    SRC_ALU  = 2'b01,
    SRC_MEM  = 2'b10,
    SRC_FPU  = 2'b11
  } src_e;

  logic                wen_q;
  logic [ADDR_W-1:0]   waddr_q;
  src_e                src_q;
  logic [NUM_XMM-1:0]  busy_q;
  logic [NUM_XMM-1:0]  busy_d;
  src_e                sel;
  logic [ADDR_W-1:0]   sel_addr;
`ifdef XMM_WB_ROUND_ROBIN_EN
  src_e                rr_q;  // source with highest priority next cycle
`endif

  always_comb begin
    sel = SRC_IDLE;
    if (!reset) begin
`ifdef XMM_WB_ROUND_ROBIN_EN
      case (rr_q)
        SRC_MEM: begin
          if (mem_valid)      sel = SRC_MEM;
          else if (fpu_valid) sel = SRC_FPU;
          else if (alu_valid) sel = SRC_ALU;
        end
        SRC_FPU: begin
          if (fpu_valid)      sel = SRC_FPU;
          else if (alu_valid) sel = SRC_ALU;
          else if (mem_valid) sel = SRC_MEM;
        end
        default: begin
          if (alu_valid)      sel = SRC_ALU;
          else if (mem_valid) sel = SRC_MEM;
          else if (fpu_valid) sel = SRC_FPU;
        end
      endcase
`else
      if (fpu_valid)      sel = SRC_FPU;
      else if (mem_valid) sel = SRC_MEM;
      else if (alu_valid) sel = SRC_ALU;
`endif
    end
  end

  always_comb begin
    sel_addr = alu_addr;
    case (sel)
      SRC_MEM: sel_addr = mem_addr;
      SRC_FPU: sel_addr = fpu_addr;
      default: sel_addr = alu_addr;
    endcase
  end

  assign alu_ready = (sel == SRC_ALU);
  assign mem_ready = (sel == SRC_MEM);
  assign fpu_ready = (sel == SRC_FPU);

  // A reservation may ride on the writeback that is retiring the same register this cycle.
  assign rsv_ok = rsv_valid && !reset &&
                  (!busy_q[rsv_addr] || (wen_q && (waddr_q == rsv_addr)));

  // Clear first, then set, so a same-cycle reservation keeps the bit.
  always_comb begin
    busy_d = busy_q;
    if (wen_q)  busy_d[waddr_q]  = 1'b0;
    if (rsv_ok) busy_d[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      src_q   <= SRC_IDLE;
      busy_q  <= '0;
`ifdef XMM_WB_ROUND_ROBIN_EN
      rr_q    <= SRC_ALU;
`endif
    end else begin
      wen_q  <= (sel != SRC_IDLE);
      src_q  <= sel;
      busy_q <= busy_d;
      if (sel != SRC_IDLE) begin
        waddr_q <= sel_addr;
`ifdef XMM_WB_ROUND_ROBIN_EN
        case (sel)
          SRC_ALU: rr_q <= SRC_MEM;
          SRC_MEM: rr_q <= SRC_FPU;
          default: rr_q <= SRC_ALU;
        endcase
`endif
      end
    end
  end

  assign xmm_write_en   = wen_q;
  assign xmm_write_addr = waddr_q;
  assign src            = src_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_xmm_writeback_arbiter.sv
// tb/tb_xmm_writeback_arbiter.sv - directed self-checking bench for xmm_writeback_arbiter
// Arbitration expectations follow XMM_WB_ROUND_ROBIN_EN when it is defined.
module tb_xmm_writeback_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic       alu_valid, mem_valid, fpu_valid;
  logic [2:0] alu_addr, mem_addr, fpu_addr;
  logic       alu_ready, mem_ready, fpu_ready;
  logic       xmm_write_en;
  logic [2:0] xmm_write_addr;
  logic [1:0] src;
  logic       rsv_valid;
  logic [2:0] rsv_addr;
  logic       rsv_ok;
  logic [7:0] busy;

  int checks = 0;
  int errors = 0;

  xmm_writeback_arbiter #(.NUM_XMM(8), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .mem_valid(mem_valid), .fpu_valid(fpu_valid),
    .alu_addr(alu_addr), .mem_addr(mem_addr), .fpu_addr(fpu_addr),
    .alu_ready(alu_ready), .mem_ready(mem_ready), .fpu_ready(fpu_ready),
    .xmm_write_en(xmm_write_en), .xmm_write_addr(xmm_write_addr), .src(src),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; mem_valid = 0; fpu_valid = 0;
    alu_addr = 0; mem_addr = 0; fpu_addr = 0;
    rsv_valid = 0; rsv_addr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; alu_valid = 1; alu_addr = 3'd2; rsv_valid = 1; rsv_addr = 3'd2;
    #1;
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL reset_alu_ready: got %b expected 0", alu_ready); end
    checks++; if (rsv_ok !== 1'b0) begin errors++; $display("FAIL reset_rsv_ok: got %b expected 0", rsv_ok); end
    tick();
    checks++; if (xmm_write_en !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b expected 0", xmm_write_en); end
    checks++; if (src !== 2'b00) begin errors++; $display("FAIL reset_src: got %b expected 00", src); end
    checks++; if (xmm_write_addr !== 3'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", xmm_write_addr); end
    checks++; if (busy !== 8'h00) begin errors++; $display("FAIL reset_busy: got %h expected 00", busy); end
    reset = 0;
    idle_inputs();
  endtask

  task automatic test_single_writeback();
    do_reset();
    alu_valid = 1; alu_addr = 3'd5;
    #1;
    checks++; if ({fpu_ready, mem_ready, alu_ready} !== 3'b001) begin errors++; $display("FAIL single_ready: got %b expected 001", {fpu_ready, mem_ready, alu_ready}); end
    tick();
    alu_valid = 0;
    checks++; if (xmm_write_en !== 1'b1) begin errors++; $display("FAIL single_wen: got %b expected 1", xmm_write_en); end
    checks++; if (xmm_write_addr !== 3'd5) begin errors++; $display("FAIL single_addr: got %0d expected 5", xmm_write_addr); end
    checks++; if (src !== 2'b01) begin errors++; $display("FAIL single_src: got %b expected 01", src); end
    tick();
    checks++; if (src !== 2'b00) begin errors++; $display("FAIL single_src_idle: got %b expected 00", src); end
    checks++; if (xmm_write_en !== 1'b0) begin errors++; $display("FAIL single_wen_idle: got %b expected 0", xmm_write_en); end
    checks++; if (xmm_write_addr !== 3'd5) begin errors++; $display("FAIL single_addr_hold: got %0d expected 5", xmm_write_addr); end
  endtask

  task automatic test_arbitration();
    logic [1:0] es;
    logic [2:0] ev;
    do_reset();
    alu_valid = 1; mem_valid = 1; fpu_valid = 1;
    alu_addr = 3'd1; mem_addr = 3'd2; fpu_addr = 3'd3;
    for (int i = 0; i < 6; i++) begin
`ifdef XMM_WB_ROUND_ROBIN_EN
      es = 2'(i % 3 + 1);
`else
      es = 2'd3;
`endif
      ev = 3'b001 << (es - 2'd1);
      #1;
      checks++; if ({fpu_ready, mem_ready, alu_ready} !== ev) begin errors++; $display("FAIL arb_ready[%0d]: got %b expected %b", i, {fpu_ready, mem_ready, alu_ready}, ev); end
      tick();
      checks++; if (src !== es || xmm_write_en !== 1'b1) begin errors++; $display("FAIL arb_src[%0d]: got %b/%b expected %b/1", i, src, xmm_write_en, es); end
      checks++; if (xmm_write_addr !== {1'b0, es}) begin errors++; $display("FAIL arb_addr[%0d]: got %0d expected %0d", i, xmm_write_addr, es); end
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    do_reset();
    alu_valid = 1; alu_addr = 3'd1; mem_valid = 1; mem_addr = 3'd2;
    #1;
`ifdef XMM_WB_ROUND_ROBIN_EN
    checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin errors++; $display("FAIL b2b_first: got alu=%b mem=%b expected alu=1 mem=0", alu_ready, mem_ready); end
    tick();
    alu_valid = 0;
    #1;
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL b2b_second_ready: got %b expected 1", mem_ready); end
    checks++; if (src !== 2'b01 || xmm_write_addr !== 3'd1) begin errors++; $display("FAIL b2b_first_wb: got src=%b addr=%0d expected 01/1", src, xmm_write_addr); end
    tick();
    mem_valid = 0;
    checks++; if (xmm_write_en !== 1'b1 || src !== 2'b10 || xmm_write_addr !== 3'd2) begin errors++; $display("FAIL b2b_second_wb: got wen=%b src=%b addr=%0d expected 1/10/2", xmm_write_en, src, xmm_write_addr); end
`else
    checks++; if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin errors++; $display("FAIL b2b_first: got alu=%b mem=%b expected alu=0 mem=1", alu_ready, mem_ready); end
    tick();
    mem_valid = 0;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL b2b_second_ready: got %b expected 1", alu_ready); end
    checks++; if (src !== 2'b10 || xmm_write_addr !== 3'd2) begin errors++; $display("FAIL b2b_first_wb: got src=%b addr=%0d expected 10/2", src, xmm_write_addr); end
    tick();
    alu_valid = 0;
    checks++; if (xmm_write_en !== 1'b1 || src !== 2'b01 || xmm_write_addr !== 3'd1) begin errors++; $display("FAIL b2b_second_wb: got wen=%b src=%b addr=%0d expected 1/01/1", xmm_write_en, src, xmm_write_addr); end
`endif
    tick();
    checks++; if (xmm_write_en !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", xmm_write_en); end
  endtask

  task automatic test_reservation();
    do_reset();
    rsv_valid = 1; rsv_addr = 3'd4;
    #1;
    checks++; if (rsv_ok !== 1'b1) begin errors++; $display("FAIL rsv_first_ok: got %b expected 1", rsv_ok); end
    tick();
    checks++; if (busy !== 8'h10) begin errors++; $display("FAIL rsv_busy_set: got %h expected 10", busy); end
    #1;
    checks++; if (rsv_ok !== 1'b0) begin errors++; $display("FAIL rsv_second_ok: got %b expected 0", rsv_ok); end
    tick();
    rsv_valid = 0; fpu_valid = 1; fpu_addr = 3'd4;
    #1;
    checks++; if (fpu_ready !== 1'b1) begin errors++; $display("FAIL rsv_fpu_ready: got %b expected 1", fpu_ready); end
    tick();
    fpu_valid = 0;
    checks++; if (xmm_write_en !== 1'b1 || src !== 2'b11 || xmm_write_addr !== 3'd4) begin errors++; $display("FAIL rsv_fpu_wb: got wen=%b src=%b addr=%0d expected 1/11/4", xmm_write_en, src, xmm_write_addr); end
    checks++; if (busy !== 8'h10) begin errors++; $display("FAIL rsv_busy_during_wb: got %h expected 10", busy); end
    tick();
    checks++; if (busy !== 8'h00) begin errors++; $display("FAIL rsv_busy_cleared: got %h expected 00", busy); end
  endtask

  task automatic test_set_wins();
    do_reset();
    rsv_valid = 1; rsv_addr = 3'd6;
    tick();
    rsv_valid = 0; alu_valid = 1; alu_addr = 3'd6;
    tick();
    alu_valid = 0; rsv_valid = 1; rsv_addr = 3'd6;
    #1;
    checks++; if (rsv_ok !== 1'b1) begin errors++; $display("FAIL setwin_rsv_ok: got %b expected 1", rsv_ok); end
    tick();
    rsv_valid = 0;
    checks++; if (busy !== 8'h40) begin errors++; $display("FAIL setwin_busy: got %h expected 40", busy); end
    mem_valid = 1; mem_addr = 3'd2;
    tick();
    mem_valid = 0;
    tick();
    checks++; if (busy !== 8'h40) begin errors++; $display("FAIL clear_wb_busy: got %h expected 40", busy); end
  endtask

  task automatic test_reset_drop();
    do_reset();
    rsv_valid = 1;
    for (int i = 0; i < 8; i++) begin
      rsv_addr = 3'(i);
      tick();
    end
    rsv_valid = 0;
    checks++; if (busy !== 8'hFF) begin errors++; $display("FAIL drop_busy_full: got %h expected ff", busy); end
    reset = 1; mem_valid = 1; mem_addr = 3'd3; rsv_valid = 1; rsv_addr = 3'd3;
    #1;
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL drop_mem_ready: got %b expected 0", mem_ready); end
    tick();
    reset = 0;
    idle_inputs();
    checks++; if (busy !== 8'h00) begin errors++; $display("FAIL drop_busy: got %h expected 00", busy); end
    checks++; if (xmm_write_en !== 1'b0 || src !== 2'b00) begin errors++; $display("FAIL drop_wb: got wen=%b src=%b expected 0/00", xmm_write_en, src); end
    tick();
    checks++; if (xmm_write_en !== 1'b0) begin errors++; $display("FAIL drop_no_replay: got %b expected 0", xmm_write_en); end
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    tick();
    test_reset();
    test_single_writeback();
    test_arbitration();
    test_back_to_back();
    test_reservation();
    test_set_wins();
    test_reset_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
